// File: rtl/network_mac_accum_requant.sv
// network_mac_accum_requant: window accumulator with round/shift/saturate requantisation and a one-entry valid/ready output register.
// Optional NETWORK_MAC_RELU_EN clamps negative results to zero before saturation.
module network_mac_accum_requant #(
  parameter int PROD_WIDTH = 30,
  parameter int ACC_WIDTH  = 40,
  parameter int OUT_WIDTH  = 16,
  parameter int FRAC_SHIFT = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PROD_WIDTH-1:0] in_prod,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_sat,
  output logic [15:0]           out_count
);
  typedef enum logic {IDLE, ACCUM} state_t;
  localparam int RW = ACC_WIDTH + 1;
  localparam logic signed [RW-1:0] HALF = {{(RW-1){1'b0}}, 1'b1} << (FRAC_SHIFT - 1);
  localparam logic signed [RW-1:0] MAXV = {{(RW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] MAXO = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  state_t                 state, state_d;
  logic [ACC_WIDTH-1:0]   acc, sum;
  logic signed [RW-1:0]   r;
  logic [15:0]            cnt, cnt_inc;
  logic [OUT_WIDTH-1:0]   q;
  logic                   accept, fin, sat, hi;
  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;
  assign fin      = accept & in_last;
  assign sum      = (state == IDLE ? '0 : acc) + {{(ACC_WIDTH-PROD_WIDTH){in_prod[PROD_WIDTH-1]}}, in_prod};
  // One extra bit keeps the rounding add from wrapping near the accumulator limit
  assign r        = ($signed({sum[ACC_WIDTH-1], sum}) + HALF) >>> FRAC_SHIFT;
  assign cnt_inc  = cnt + 16'(cnt != 16'hFFFF);
  assign hi       = r > MAXV;
`ifdef NETWORK_MAC_RELU_EN
  always_comb begin
    q   = r[RW-1] ? '0 : hi ? MAXO : r[OUT_WIDTH-1:0];
    sat = hi;
  end
`else
  localparam logic signed [RW-1:0] MINV = {{(RW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
  logic lo;
  always_comb begin
    lo  = r < MINV;
    q   = hi ? MAXO : lo ? ~MAXO : r[OUT_WIDTH-1:0];
    sat = hi | lo;
  end
`endif
  always_comb begin
    state_d = accept ? (in_last ? IDLE : ACCUM) : state;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_d;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      out_count <= '0;
    end else begin
      out_valid <= fin | (out_valid & ~out_ready);
      if (accept) begin
        acc <= in_last ? '0 : sum;
        cnt <= in_last ? '0 : cnt_inc;
      end
      if (fin) begin
        out_data  <= q;
        out_sat   <= sat;
        out_count <= cnt_inc;
      end
    end
  end
endmodule

// File: tb/tb_network_mac_accum_requant.sv
// tb_network_mac_accum_requant: randomized scoreboard bench against an arithmetic reference model.
module tb_network_mac_accum_requant;
  localparam int FS = 14;
  typedef struct {
    longint d;
    longint s;
    longint c;
  } exp_t;

  logic               clk = 0;
  logic               reset = 1;
  logic               in_valid = 0, in_last = 0, out_ready = 1;
  logic signed [29:0] in_prod = '0;
  logic               in_ready, out_valid, out_sat;
  logic [15:0]        out_data, out_count;

  network_mac_accum_requant dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_prod(in_prod), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
    .out_count(out_count)
  );

  always #5 clk = ~clk;

  exp_t   sb[$];
  int     checks = 0, passed = 0, pushed = 0, popped = 0;
  longint m_sum = 0;
  int     m_cnt = 0;
  bit     took;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic void model(input logic signed [29:0] p, input bit last);
    longint s, r;
    exp_t   e;
    s = m_sum + longint'(p);
    m_cnt = m_cnt + 1;
    if (!last) begin
      m_sum = s;
      return;
    end
    r = (s + (64'sd1 <<< (FS - 1))) >>> FS;
    e.s = 0;
`ifdef NETWORK_MAC_RELU_EN
    if (r < 0) r = 0;
`endif
    if (r > 32767) begin r = 32767; e.s = 1; end
    else if (r < -32768) begin r = -32768; e.s = 1; end
    e.d = r;
    e.c = m_cnt > 65535 ? 65535 : m_cnt;
    sb.push_back(e);
    pushed++;
    m_sum = 0;
    m_cnt = 0;
  endfunction

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      popped++;
      if (sb.size() == 0) chk("unexpected_result", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_data", longint'($signed(out_data)), e.d);
        chk("out_sat", longint'(out_sat), e.s);
        chk("out_count", longint'(out_count), e.c);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    took = in_valid && in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic signed [29:0] p, input bit last, input bit rnd);
    int g = 0;
    in_valid = 1; in_prod = p; in_last = last;
    do begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      tick();
      g++;
    end while (!took && g < 1000);
    in_valid = 0; in_last = 0;
    if (!took) chk("accept_timeout", 0, 1);
    else model(p, last);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] held;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_count", out_count, 0);
    @(posedge clk); #1;
    reset = 0;
    // rounding: half rounds toward +inf
    send(30'sd8192, 1, 0);
    send(-30'sd8192, 1, 0);
    send(-30'sd8193, 1, 0);
    // saturation at both bounds
    send(30'sd536870911, 0, 0);
    send(30'sd536870911, 1, 0);
    send(-30'sd536870912, 0, 0);
    send(-30'sd536870912, 1, 0);
    send(-30'sd8193, 1, 0);
    tick(); tick();
    // asynchronous reset in the middle of a window
    send(30'sd100000, 0, 0);
    send(30'sd200000, 0, 0);
    #3;
    reset = 1;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_data", out_data, 0);
    chk("async_rst_count", out_count, 0);
    chk("async_rst_sat", out_sat, 0);
    m_sum = 0; m_cnt = 0;
    @(posedge clk); #1;
    reset = 0;
    send(30'sd49152, 0, 0);
    send(30'sd16384, 1, 0);
    tick();
    // back-pressure: pending result blocks input and holds output
    out_ready = 0;
    send(30'sd163840, 1, 0);
    held = out_data;
    chk("bp_valid", out_valid, 1);
    in_valid = 1; in_prod = 30'sd32768; in_last = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_in_ready", took, 0);
      chk("bp_hold", out_data, held);
    end
    out_ready = 1;
    send(30'sd32768, 1, 0);
    chk("bp_reload_valid", out_valid, 1);
    chk("bp_reload_data", out_data, 2);
    tick();
    // streaming windows with random lengths and random back-pressure
    for (int w = 0; w < 1000; w++) begin
      int len;
      len = $urandom_range(1, 64);
      for (int k = 0; k < len; k++) begin
        logic signed [29:0] p;
        int v;
        v = $urandom_range(0, 2097152) - 1048576;
        p = $urandom_range(0, 1) ? 30'($urandom) : 30'(v);
        send(p, k == len - 1, 1);
      end
    end
    out_ready = 1;
    for (int i = 0; i < 100 && sb.size() != 0; i++) tick();
    tick();
    chk("drain_empty", sb.size(), 0);
    chk("results_count", popped, pushed);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
